// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for the word-side SRAM port (state enum, half-word merge).
package sram_pkg;
  typedef enum logic [2:0] {IDLE, RD_LO, WR_LO, RD_HI, WR_HI, RESP} state_e;
  localparam int HW_W = 16;
  localparam logic [1:0] WBE_WR = 2'b11;
  localparam logic [1:0] WBE_RD = 2'b00;
  function automatic logic [HW_W-1:0] merge_hw(input logic [HW_W-1:0] old_hw, input logic [HW_W-1:0] new_hw, input logic [1:0] mask2);
    return {mask2[1] ? new_hw[15:8] : old_hw[15:8], mask2[0] ? new_hw[7:0] : old_hw[7:0]};
  endfunction
endpackage

// File: rtl/sram_word_port.sv
// sram_word_port: 32-bit request to 16-bit half-word SRAM sequencer; SRAM_WORD_RMW_EN enables read-modify-write of partial halves.
module sram_word_port
  import sram_pkg::*;
#(
  parameter int AWIDTH = 19,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-2:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  input  logic [3:0]        req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic [HW_W-1:0]   sram_d,
  output logic [AWIDTH-1:0] sram_addr,
  output logic [1:0]        sram_wbe,
  output logic              sram_en,
  input  logic [HW_W-1:0]   sram_q
);
  state_e state_q, state_d, lo_first, hi_first;
  logic [AWIDTH-2:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] mask_q, mask_d, m, em;
  logic [HW_W-1:0] sram_d_q, sram_d_d;
  logic [AWIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [1:0] sram_wbe_q, sram_wbe_d;
  logic sram_en_q, sram_en_d, is_rd, accept, half;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rdata_q     <= '0;
      sram_d_q    <= '0;
      sram_addr_q <= '0;
      sram_wbe_q  <= WBE_RD;
      sram_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      rdata_q     <= rdata_d;
      sram_d_q    <= sram_d_d;
      sram_addr_q <= sram_addr_d;
      sram_wbe_q  <= sram_wbe_d;
      sram_en_q   <= sram_en_d;
    end
  end
  // Without RMW a partially-masked half is widened and written whole.
  always_comb begin
    accept = req_valid & (state_q == IDLE);
    m = (state_q == IDLE) ? req_wmask : mask_q;
`ifdef SRAM_WORD_RMW_EN
    em = m;
`else
    em = {{2{|m[3:2]}}, {2{|m[1:0]}}};
`endif
    is_rd = ~|m;
    hi_first = is_rd ? RD_HI : (em[3:2] == 2'b00) ? RESP : (em[3:2] == 2'b11) ? WR_HI : RD_HI;
    lo_first = is_rd ? RD_LO : (em[1:0] == 2'b00) ? hi_first : (em[1:0] == 2'b11) ? WR_LO : RD_LO;
    case (state_q)
      IDLE:    state_d = accept ? lo_first : IDLE;
      RD_LO:   state_d = is_rd ? RD_HI : WR_LO;
      WR_LO:   state_d = hi_first;
      RD_HI:   state_d = is_rd ? RESP : WR_HI;
      WR_HI:   state_d = RESP;
      RESP:    state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they span the whole state cycle.
  always_comb begin
    addr_d = accept ? req_addr : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    mask_d = accept ? em : mask_q;
    half = (state_d == RD_HI) || (state_d == WR_HI);
    sram_en_d = (state_d != IDLE) && (state_d != RESP);
    sram_wbe_d = (state_d == WR_LO || state_d == WR_HI) ? WBE_WR : WBE_RD;
    sram_addr_d = sram_en_d ? {addr_d, half} : sram_addr_q;
    sram_d_d = (state_d == WR_LO) ? merge_hw(sram_q, wdata_d[15:0], mask_d[1:0]) :
               (state_d == WR_HI) ? merge_hw(sram_q, wdata_d[31:16], mask_d[3:2]) : '0;
    rdata_d = (state_q == RD_LO) ? {rdata_q[31:16], sram_q} :
              (state_q == RD_HI) ? {sram_q, rdata_q[15:0]} : rdata_q;
  end
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign sram_d     = sram_d_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wbe   = sram_wbe_q;
  assign sram_en    = sram_en_q;
endmodule

// File: tb/tb_sram_word_port.sv
// tb_sram_word_port: randomized self-checking bench with a byte-level reference memory; honours SRAM_WORD_RMW_EN.
module tb_sram_word_port;
  localparam int AW = 19;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, sram_en;
  logic [AW-2:0] req_addr = '0;
  logic [31:0] req_wdata = '0, resp_rdata;
  logic [3:0] req_wmask = '0;
  logic [15:0] sram_d, sram_q;
  logic [AW-1:0] sram_addr;
  logic [1:0] sram_wbe;
  bit [15:0] mem [0:(1<<AW)-1];
  bit [7:0] ref_b [int];
  int passed = 0, total = 0, n_rd = 0, n_wr = 0;
  logic [AW-1:0] log_a [$];

  sram_word_port #(.AWIDTH(AW), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .sram_d(sram_d), .sram_addr(sram_addr), .sram_wbe(sram_wbe),
    .sram_en(sram_en), .sram_q(sram_q)
  );

  always #5 clk = ~clk;
  assign sram_q = mem[sram_addr];

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wbe == 2'b11) begin
        mem[sram_addr] = sram_d;
        n_wr++;
      end else n_rd++;
      log_a.push_back(sram_addr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_word(input int w);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) v[8*b +: 8] = ref_b.exists(w*4+b) ? ref_b[w*4+b] : 8'h00;
    return v;
  endfunction

  task automatic preload(input int w, input logic [31:0] v);
    mem[2*w] = v[15:0];
    mem[2*w+1] = v[31:16];
    for (int b = 0; b < 4; b++) ref_b[w*4+b] = v[8*b +: 8];
  endtask

  task automatic do_req(input int w, input logic [31:0] wd, input logic [3:0] wm, input int hold);
    logic [3:0] em;
    logic [31:0] exp_data, held;
    int exp_rd, exp_wr, k, prev;
    bit bad;
`ifdef SRAM_WORD_RMW_EN
    em = wm;
`else
    em = {{2{|wm[3:2]}}, {2{|wm[1:0]}}};
`endif
    exp_rd = 0;
    exp_wr = 0;
    for (int h = 0; h < 2; h++) begin
      if (em[2*h +: 2] != 2'b00) exp_wr++;
      if (em[2*h +: 2] == 2'b01 || em[2*h +: 2] == 2'b10) exp_rd++;
    end
    if (wm == 4'h0) exp_rd = 2;
    exp_data = ref_word(w);
    for (int b = 0; b < 4; b++) if (em[b]) ref_b[w*4+b] = wd[8*b +: 8];
    req_valid = 1'b1;
    req_addr = w[AW-2:0];
    req_wdata = wd;
    req_wmask = wm;
    total++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    else passed++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_rd = 0;
    n_wr = 0;
    log_a.delete();
    k = 0;
    while (resp_valid !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (k !== exp_rd + exp_wr) $display("FAIL latency w=%0h m=%0h: got %0d expected %0d", w, wm, k, exp_rd + exp_wr);
    else passed++;
    total++;
    if (n_rd !== exp_rd || n_wr !== exp_wr) $display("FAIL cycles w=%0h m=%0h: got rd=%0d wr=%0d expected rd=%0d wr=%0d", w, wm, n_rd, n_wr, exp_rd, exp_wr);
    else passed++;
    bad = 0;
    prev = 0;
    foreach (log_a[i]) begin
      if (log_a[i][AW-1:1] !== w[AW-2:0] || int'(log_a[i][0]) < prev) bad = 1;
      prev = int'(log_a[i][0]);
    end
    total++;
    if (bad) $display("FAIL sram_addr w=%0h: got first %0h expected word %0h ascending halves", w, log_a.size() > 0 ? log_a[0] : '0, w);
    else passed++;
    if (wm == 4'h0) begin
      total++;
      if (resp_rdata !== exp_data) $display("FAIL rdata w=%0h: got %h expected %h", w, resp_rdata, exp_data);
      else passed++;
    end
    held = resp_rdata;
    repeat (hold) begin
      @(posedge clk); #1;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0)
        $display("FAIL hold: got valid=%b rdata=%h ready=%b expected 1 %h 0", resp_valid, resp_rdata, req_ready, held);
      else passed++;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || sram_en !== 1'b0)
      $display("FAIL release: got valid=%b ready=%b en=%b expected 0 1 0", resp_valid, req_ready, sram_en);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || sram_en !== 1'b0 || sram_wbe !== 2'b00 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || sram_addr !== '0)
      $display("FAIL reset: got ready=%b en=%b wbe=%b valid=%b rdata=%h addr=%h expected 1 0 00 0 0 0", req_ready, sram_en, sram_wbe, resp_valid, resp_rdata, sram_addr);
    else passed++;
  endtask

  task automatic test_read();
    preload(32'h10, 32'hDEADBEEF);
    do_req(32'h10, 32'h0, 4'h0, 0);
  endtask

  task automatic test_full_write();
    do_req(5, 32'hCAFEF00D, 4'hF, 0);
    total++;
    if (mem[10] !== 16'hF00D || mem[11] !== 16'hCAFE) $display("FAIL full_write: got %h %h expected cafe f00d", mem[11], mem[10]);
    else passed++;
  endtask

  task automatic test_partial();
    logic [15:0] exp_hi;
`ifdef SRAM_WORD_RMW_EN
    exp_hi = 16'h11BB;
`else
    exp_hi = 16'hAABB;
`endif
    preload(7, 32'h11223344);
    do_req(7, 32'hAABBCCDD, 4'b0100, 0);
    total++;
    if (mem[15] !== exp_hi || mem[14] !== 16'h3344) $display("FAIL partial: got %h%h expected %h3344", mem[15], mem[14], exp_hi);
    else passed++;
    do_req(7, 32'h0, 4'h0, 0);
  endtask

  task automatic test_backpressure();
    preload(9, 32'h0BADCAFE);
    do_req(9, 32'h0, 4'h0, 5);
  endtask

  task automatic test_wrap();
    do_req((1 << (AW-1)) - 1, 32'h5A5AA5A5, 4'hF, 0);
    do_req((1 << (AW-1)) - 1, 32'h0, 4'h0, 0);
  endtask

  task automatic test_back_to_back();
    for (int w = 1000; w < 1008; w++) preload(w, $urandom);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] wm;
      wm = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      do_req(1000 + $urandom_range(0, 7), $urandom, wm, $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1;
    req_addr = 100;
    req_wdata = 32'h12345678;
    req_wmask = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (sram_wbe !== 2'b11 || sram_en !== 1'b1) $display("FAIL in_wr_lo: got wbe=%b en=%b expected 11 1", sram_wbe, sram_en);
    else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (sram_wbe !== 2'b00 || sram_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL reset_mid: got wbe=%b en=%b valid=%b ready=%b expected 00 0 0 1", sram_wbe, sram_en, resp_valid, req_ready);
    else passed++;
    repeat (4) begin
      @(posedge clk); #1;
      total++;
      if (resp_valid !== 1'b0 || sram_en !== 1'b0) $display("FAIL after_reset: got valid=%b en=%b expected 0 0", resp_valid, sram_en);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_full_write();
    test_partial();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
